sap1_controller: RTL and testbench

SAP1_CONTROLLER -- requirements
Module: sap1_controller

---
 rtl/sap1_controller.sv | 178 +++++++++++++++++
 tb/tb_sap1_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sap1_controller.sv
// rtl/sap1_controller.sv - SAP-1 ring-counter sequencer and control-word decoder
//
// Purpose: generates the six-state one-hot T-state ring and decodes the SAP-1
// control word for LDA, ADD, SUB, OUT and HLT.
// Optional feature: define SAP1_VARIABLE_RING_EN so the ring returns to T1
// right after the last state an instruction actually uses.
//
// Ports:
//   CLK      in   system clock, rising edge
//   CLR      in   synchronous active-high reset; also blanks all controls
//   prog     in   1 = run, 0 = program mode (ring parked at T1, controls idle)
//   op       in   [3:0] opcode from the instruction register upper nibble
//   t_state  out  [5:0] one-hot ring state, bit0 = T1 ... bit5 = T6
//   hlt      out  set once HLT executes, cleared only by CLR
//   Cp, Ep, Ea, Su, Eu                   out  active-high controls
//   nLm, nCE, nLi, nEi, nLa, nLb, nLo    out  active-low controls
module sap1_controller (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       prog,
  input  logic [3:0] op,
  output logic [5:0] t_state,
  output logic       hlt,
  output logic       Cp,
  output logic       Ep,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       nLm,
  output logic       nCE,
  output logic       nLi,
  output logic       nEi,
  output logic       nLa,
  output logic       nLb,
  output logic       nLo
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [5:0] t_next;
  logic       hlt_next;
  logic [5:0] last_state;

  // Last ring state the current instruction needs before wrapping to T1.
  always_comb begin
    last_state = T6;
`ifdef SAP1_VARIABLE_RING_EN
    case (op)
      OP_LDA:         last_state = T5;
      OP_ADD, OP_SUB: last_state = T6;
      OP_OUT:         last_state = T4;
      OP_HLT:         last_state = T6;
      default:        last_state = T3;
    endcase
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      t_state <= T1;
      hlt     <= 1'b0;
    end else begin
      t_state <= t_next;
      hlt     <= hlt_next;
    end
  end

  // Next-state logic. A halted controller stays frozen whatever prog does;
  // only CLR releases it.
  always_comb begin
    t_next   = t_state;
    hlt_next = hlt;
    if (hlt) begin
      t_next = t_state;
    end else if (!prog) begin
      t_next = T1;
    end else if (t_state == T4 && op == OP_HLT) begin
      hlt_next = 1'b1;
      t_next   = T4;
    end else if (t_state == last_state) begin
      t_next = T1;
    end else begin
      case (t_state)
        T1:      t_next = T2;
        T2:      t_next = T3;
        T3:      t_next = T4;
        T4:      t_next = T5;
        T5:      t_next = T6;
        default: t_next = T1;  // also recovers from a non-one-hot value
      endcase
    end
  end

  // Control-word decode
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    nLm = 1'b1;
    nCE = 1'b1;
    nLi = 1'b1;
    nEi = 1'b1;
    nLa = 1'b1;
    nLb = 1'b1;
    nLo = 1'b1;
    if (!CLR && !hlt && prog) begin
      case (t_state)
        T1: begin
          Ep  = 1'b1;
          nLm = 1'b0;
        end
        T2: begin
          Cp = 1'b1;
        end
        T3: begin
          nCE = 1'b0;
          nLi = 1'b0;
        end
        T4: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: begin
              nLm = 1'b0;
              nEi = 1'b0;
            end
            OP_OUT: begin
              Ea  = 1'b1;
              nLo = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (op)
            OP_LDA: begin
              nCE = 1'b0;
              nLa = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              nCE = 1'b0;
              nLb = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          case (op)
            OP_ADD: begin
              Eu  = 1'b1;
              nLa = 1'b0;
            end
            OP_SUB: begin
              Eu  = 1'b1;
              Su  = 1'b1;
              nLa = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// tb/tb_sap1_controller.sv - self-checking bench for sap1_controller
module tb_sap1_controller;

  logic       CLK;
  logic       CLR;
  logic       prog;
  logic [3:0] op;
  logic [5:0] t_state;
  logic       hlt;
  logic       Cp, Ep, Ea, Su, Eu;
  logic       nLm, nCE, nLi, nEi, nLa, nLb, nLo;

  sap1_controller dut (
    .CLK(CLK), .CLR(CLR), .prog(prog), .op(op),
    .t_state(t_state), .hlt(hlt),
    .Cp(Cp), .Ep(Ep), .Ea(Ea), .Su(Su), .Eu(Eu),
    .nLm(nLm), .nCE(nCE), .nLi(nLi), .nEi(nEi),
    .nLa(nLa), .nLb(nLb), .nLo(nLo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control vector bit positions
  localparam int I_CP = 11, I_EP = 10, I_EA = 9, I_SU = 8, I_EU = 7;
  localparam int I_NLM = 6, I_NCE = 5, I_NLI = 4, I_NEI = 3, I_NLA = 2, I_NLB = 1, I_NLO = 0;
  localparam logic [11:0] INACTIVE = 12'h07F;

  logic [11:0] dut_ctrl;
  assign dut_ctrl = {Cp, Ep, Ea, Su, Eu, nLm, nCE, nLi, nEi, nLa, nLb, nLo};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: ring step 1..6, halt flag, known-after-reset flag
  int m_step  = 1;
  bit m_halt  = 0;
  bit m_valid = 0;

  function automatic int last_step(input logic [3:0] o);
`ifdef SAP1_VARIABLE_RING_EN
    if (o == 4'd0) return 5;
    if (o == 4'd1 || o == 4'd2 || o == 4'd15) return 6;
    if (o == 4'd14) return 4;
    return 3;
`else
    return 6;
`endif
  endfunction

  function automatic logic [11:0] model_ctrl(input int s, input logic [3:0] o, input bit live);
    logic [11:0] c;
    bit alu;
    c = INACTIVE;
    alu = (o == 4'd1) || (o == 4'd2);
    if (live) begin
      if (s == 1) begin c[I_EP] = 1'b1; c[I_NLM] = 1'b0; end
      if (s == 2) c[I_CP] = 1'b1;
      if (s == 3) begin c[I_NCE] = 1'b0; c[I_NLI] = 1'b0; end
      if (s == 4 && (o == 4'd0 || alu)) begin c[I_NLM] = 1'b0; c[I_NEI] = 1'b0; end
      if (s == 4 && o == 4'd14) begin c[I_EA] = 1'b1; c[I_NLO] = 1'b0; end
      if (s == 5 && o == 4'd0) begin c[I_NCE] = 1'b0; c[I_NLA] = 1'b0; end
      if (s == 5 && alu) begin c[I_NCE] = 1'b0; c[I_NLB] = 1'b0; end
      if (s == 6 && alu) begin c[I_EU] = 1'b1; c[I_NLA] = 1'b0; c[I_SU] = (o == 4'd2); end
    end
    return c;
  endfunction

  // One clock: apply inputs after the falling edge, check outputs, then
  // take the rising edge and advance the model.
  task automatic step(input bit clr, input bit pg, input logic [3:0] o);
    logic [11:0] exp_c;
    logic [5:0]  exp_t;
    CLR  = clr;
    prog = pg;
    op   = o;
    #1;
    exp_c = model_ctrl(m_step, o, !clr && pg && !m_halt && m_valid);
    n_assert++;
    assert (dut_ctrl === exp_c) else begin
      n_fail++;
      $error("FAIL ctrl step=T%0d op=%h clr=%0d prog=%0d observed=%h expected=%h",
             m_step, o, clr, pg, dut_ctrl, exp_c);
    end
    if (m_valid) begin
      exp_t = 6'b1 << (m_step - 1);
      n_assert++;
      assert (t_state === exp_t) else begin
        n_fail++;
        $error("FAIL t_state observed=%b expected=%b", t_state, exp_t);
      end
      n_assert++;
      assert (hlt === m_halt) else begin
        n_fail++;
        $error("FAIL hlt observed=%b expected=%b", hlt, m_halt);
      end
    end
    @(posedge CLK);
    if (clr) begin
      m_step = 1; m_halt = 0; m_valid = 1;
    end else if (!m_valid || m_halt) begin
      // unknown or frozen
    end else if (!pg) begin
      m_step = 1;
    end else if (m_step == 4 && o == 4'd15) begin
      m_halt = 1;
    end else if (m_step >= last_step(o)) begin
      m_step = 1;
    end else begin
      m_step = m_step + 1;
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [3:0] r_op;
    CLR = 1'b1; prog = 1'b0; op = 4'd0;
    @(negedge CLK);

    // LDA through a full ring
    step(1, 1, 4'd0);
    for (int i = 0; i < 7; i++) step(0, 1, 4'd0);

    // SUB through a full ring
    step(1, 1, 4'd2);
    for (int i = 0; i < 7; i++) step(0, 1, 4'd2);

    // ADD and OUT
    step(1, 1, 4'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 4'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 4'd14);

    // HLT freezes at T4 for ten cycles, then CLR releases
    step(1, 1, 4'd15);
    for (int i = 0; i < 14; i++) step(0, 1, 4'd15);
    step(1, 1, 4'd15);
    step(0, 1, 4'd0);

    // prog drops at T3, then returns
    step(1, 1, 4'd0);
    step(0, 1, 4'd0);
    step(0, 1, 4'd0);
    step(0, 0, 4'd0);
    step(0, 0, 4'd0);
    step(0, 1, 4'd0);
    step(0, 1, 4'd0);

    // CLR and prog=0 together mid-T5
    step(1, 1, 4'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'd0);
    step(1, 0, 4'd0);
    step(0, 1, 4'd0);

    // NOP ring (short ring when the variable-ring feature is built in)
    step(1, 1, 4'd5);
    for (int i = 0; i < 7; i++) step(0, 1, 4'd5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0: r_op = 4'd0;
        1: r_op = 4'd1;
        2: r_op = 4'd2;
        3: r_op = 4'd14;
        4: r_op = 4'd15;
        5: r_op = 4'd5;
        default: r_op = 4'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 23) == 0, $urandom_range(0, 9) != 0, r_op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
